// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word width, idle fill pattern and the link state encoding.
package spi_pkg;

    localparam int unsigned SPI_DATA_W    = 8;
    localparam logic [7:0]  SPI_IDLE_FILL = 8'h00;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall detection
// one flop past the last synchronizer stage.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled pins, byte-level rx strobe and a single-entry
// tx holding buffer that is consumed at every word boundary.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned       DATA_W      = SPI_DATA_W,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = DATA_W'(SPI_IDLE_FILL)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sck_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              busy_o,
    output logic              tx_underrun_o
);

    localparam int unsigned CNT_W      = $clog2(DATA_W + 1);
    localparam int unsigned SETTLE_MAX = SYNC_STAGES + 1;
    localparam int unsigned SETTLE_W   = $clog2(SYNC_STAGES + 2);

    logic sck_level_unused, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(sck_i),
        .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(cs_i),
        .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(mosi_i),
        .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    spi_state_e state_q, state_d;
    logic       start, stop;

    logic [DATA_W-1:0]   tx_buf_q, tx_buf_d;
    logic                tx_full_q, tx_full_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                word_done_q, word_done_d;
    logic                miso_q, miso_d;
    logic                underrun_q, underrun_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                armed_q, armed_d;
    logic                settle_done;
    logic                reload;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d = ST_SHIFT;
                    start   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    stop    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state_q == ST_SHIFT);
        miso_oe_o = (state_q == ST_SHIFT);
    end

    // A frame already running when reset releases must not be joined: accept a
    // cs falling edge only after the synchronizer has flushed and cs was seen high.
    assign settle_done = (settle_q == SETTLE_W'(SETTLE_MAX));

    always_comb begin
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = word_done_q;
        miso_d      = miso_q;
        underrun_d  = underrun_q;
        settle_d    = settle_done ? settle_q : settle_q + SETTLE_W'(1);
        armed_d     = armed_q | (settle_done & cs_level);
        reload      = 1'b0;

        if (stop) begin
            bit_cnt_d   = '0;
            word_done_d = 1'b0;
            miso_d      = 1'b0;
        end else if (start) begin
            reload      = 1'b1;
            bit_cnt_d   = '0;
            word_done_d = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            if (bit_cnt_q == CNT_W'(DATA_W)) begin
                rx_data_d   = rx_shift_q;
                rx_valid_d  = 1'b1;
                bit_cnt_d   = '0;
                word_done_d = 1'b1;
            end else if (sck_rise) begin
                rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            end else if (sck_fall) begin
                if (bit_cnt_q != '0) begin
                    tx_shift_d = tx_shift_q << 1;
                    miso_d     = tx_shift_q[DATA_W-2];
                end else if (word_done_q) begin
                    reload = 1'b1;
                end
            end
        end

        if (reload) begin
            tx_shift_d = tx_full_q ? tx_buf_q : IDLE_FILL;
            miso_d     = tx_shift_d[DATA_W-1];
            underrun_d = underrun_q | ~tx_full_q;
            tx_full_d  = 1'b0;
        end

        // Checked against the pre-reload flag so a coincident load refills the buffer.
        if (tx_load_i && !tx_full_q) begin
            tx_buf_d  = tx_data_i;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            miso_q      <= 1'b0;
            underrun_q  <= 1'b0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
            miso_q      <= miso_d;
            underrun_q  <= underrun_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    assign miso_o        = miso_q;
    assign tx_ready_o    = ~tx_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master plus a word-level model of the
// tx buffer, underrun flag and received-word stream.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n, sck, cs, mosi, tx_load;
    logic [7:0] tx_data;
    logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun;
    logic [7:0] rx_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_buf;
    bit         m_full, m_underrun, m_active;
    logic [7:0] m_rx_last;
    logic [7:0] exp_rx[$];
    int         rx_count;

    logic [7:0] exp_miso [0:15];
    logic [7:0] seen_miso[0:15];
    logic [7:0] f_mosi   [0:15];
    bit         f_load   [0:16];
    logic [7:0] f_loadv  [0:16];
    int         f_n, f_abort;
    bit         f_spur;

    int   cs_stable;
    logic cs_prev, rxv_prev;

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_FILL(8'h00)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .cs_i(cs), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe), .tx_data_i(tx_data), .tx_load_i(tx_load),
        .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .busy_o(busy), .tx_underrun_o(tx_underrun)
    );

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every word boundary takes the buffered word, or the idle fill with underrun.
    function automatic logic [7:0] m_boundary();
        logic [7:0] v;
        if (m_full) begin
            v      = m_buf;
            m_full = 1'b0;
        end else begin
            v          = 8'h00;
            m_underrun = 1'b1;
        end
        return v;
    endfunction

    task automatic m_load(input logic [7:0] v);
        check1("tx_ready_before_load", tx_ready, ~m_full);
        tx_data = v;
        tx_load = 1'b1;
        wait_cyc(1);
        tx_load = 1'b0;
        if (!m_full) begin
            m_buf  = v;
            m_full = 1'b1;
        end
        check1("tx_ready_after_load", tx_ready, ~m_full);
    endtask

    task automatic m_reset();
        m_full     = 1'b0;
        m_underrun = 1'b0;
        m_active   = 1'b0;
        m_rx_last  = 8'h00;
        exp_rx.delete();
    endtask

    task automatic clear_frame();
        f_n     = 1;
        f_abort = 0;
        f_spur  = 1'b0;
        for (int k = 0; k < 17; k++) begin
            f_load[k]  = 1'b0;
            f_loadv[k] = 8'h00;
        end
    endtask

    task automatic run_frame();
        int         ph, nb, used;
        logic [7:0] win;
        ph = $urandom_range(5, 8);
        if (f_load[0]) m_load(f_loadv[0]);
        wait_cyc(ph);
        cs          = 1'b0;
        m_active    = 1'b1;
        exp_miso[0] = m_boundary();
        wait_cyc(ph);
        check1("tx_ready_frame_start", tx_ready, ~m_full);
        for (int w = 0; w < f_n; w++) begin
            nb  = (w == f_n - 1 && f_abort > 0) ? f_abort : 8;
            win = 8'h00;
            for (int b = 0; b < nb; b++) begin
                mosi = f_mosi[w][7-b];
                wait_cyc(ph);
                win = {win[6:0], miso};
                if (b == 7) exp_rx.push_back(f_mosi[w]);
                sck  = 1'b1;
                used = 0;
                if (b == 2 && f_load[w+1]) begin
                    m_load(f_loadv[w+1]);
                    used++;
                end
                if (b == 4 && f_spur) begin
                    m_load(8'($urandom));
                    used++;
                end
                wait_cyc(ph - used);
                sck = 1'b0;
            end
            if (nb == 8) begin
                seen_miso[w] = win;
                check8("miso_word", win, exp_miso[w]);
                exp_miso[w+1] = m_boundary();
            end
        end
        wait_cyc(ph);
        cs       = 1'b1;
        m_active = 1'b0;
        mosi     = 1'b0;
        wait_cyc(ph + 4);
        check_int("rx_pending", exp_rx.size(), 0);
        check1("tx_underrun", tx_underrun, m_underrun);
        check1("tx_ready_idle", tx_ready, ~m_full);
    endtask

    // Per-cycle compare against the model, sampled on the falling clock edge.
    initial begin
        cs_stable = 0;
        cs_prev   = 1'b1;
        rxv_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (cs === cs_prev) begin
                if (cs_stable < 1000) cs_stable++;
            end else begin
                cs_stable = 0;
            end
            cs_prev = cs;
            if (rst_n === 1'b1) begin
                if (rx_valid === 1'b1) begin
                    rx_count++;
                    check1("rx_valid_width", rxv_prev, 1'b0);
                    if (exp_rx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: got %02h expected no word at %0t", rx_data, $time);
                    end else begin
                        m_rx_last = exp_rx.pop_front();
                    end
                end
                check8("rx_data", rx_data, m_rx_last);
                if (cs_stable >= 5) begin
                    check1("busy", busy, m_active);
                    check1("miso_oe", miso_oe, m_active);
                    if (!m_active) check1("miso_idle", miso, 1'b0);
                end
            end
            rxv_prev = (rx_valid === 1'b1);
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int c0;
        rst_n    = 1'b0;
        sck      = 1'b0;
        cs       = 1'b1;
        mosi     = 1'b0;
        tx_load  = 1'b0;
        tx_data  = 8'h00;
        m_buf    = 8'h00;
        rx_count = 0;
        m_reset();
        clear_frame();
        repeat (3) @(posedge clk);
        #1;
        check1("rst_miso", miso, 1'b0);
        check1("rst_miso_oe", miso_oe, 1'b0);
        check1("rst_tx_ready", tx_ready, 1'b1);
        check8("rst_rx_data", rx_data, 8'h00);
        check1("rst_rx_valid", rx_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_underrun", tx_underrun, 1'b0);
        rst_n = 1'b1;
        wait_cyc(10);

        // Single word, A5 out / 1F in; filler absorbed by the closing sck fall.
        clear_frame();
        f_mosi[0] = 8'd31; f_load[0] = 1'b1; f_loadv[0] = 8'hA5; f_load[1] = 1'b1; f_loadv[1] = 8'hEE;
        c0 = rx_count;
        run_frame();
        check8("t1_rx_data", rx_data, 8'h1F);
        check8("t1_miso", seen_miso[0], 8'hA5);
        check_int("t1_rx_pulses", rx_count - c0, 1);

        clear_frame();
        f_mosi[0] = 8'b01011100; f_load[0] = 1'b1; f_loadv[0] = 8'h3C; f_load[1] = 1'b1; f_loadv[1] = 8'h11;
        c0 = rx_count;
        run_frame();
        check8("t2_rx_data", rx_data, 8'h5C);
        check8("t2_miso", seen_miso[0], 8'h3C);
        check_int("t2_rx_pulses", rx_count - c0, 1);

        clear_frame();
        f_n = 2;
        f_mosi[0] = 8'h12; f_mosi[1] = 8'h34;
        f_load[0] = 1'b1; f_loadv[0] = 8'hC3;
        f_load[1] = 1'b1; f_loadv[1] = 8'h96;
        f_load[2] = 1'b1; f_loadv[2] = 8'h22;
        c0 = rx_count;
        run_frame();
        check8("t3_miso0", seen_miso[0], 8'hC3);
        check8("t3_miso1", seen_miso[1], 8'h96);
        check8("t3_rx_data", rx_data, 8'h34);
        check_int("t3_rx_pulses", rx_count - c0, 2);
        check1("t3_no_underrun", tx_underrun, 1'b0);

        clear_frame();
        f_mosi[0] = 8'h6B;
        run_frame();
        check8("t4_miso_fill", seen_miso[0], 8'h00);
        check1("t4_underrun", tx_underrun, 1'b1);
        wait_cyc(20);
        check1("t4_underrun_sticky", tx_underrun, 1'b1);

        clear_frame();
        f_mosi[0] = 8'hB6; f_abort = 3;
        c0 = rx_count;
        run_frame();
        check_int("t5_abort_no_rx", rx_count - c0, 0);
        check1("t5_miso_oe", miso_oe, 1'b0);
        clear_frame();
        f_mosi[0] = 8'hF0; f_load[0] = 1'b1; f_loadv[0] = 8'h5A;
        run_frame();
        check8("t5_rx_data", rx_data, 8'hF0);
        check8("t5_miso", seen_miso[0], 8'h5A);

        // Reset in the middle of a word; the rest of that frame must be ignored.
        m_load(8'h77);
        wait_cyc(6);
        cs       = 1'b0;
        m_active = 1'b1;
        void'(m_boundary());
        wait_cyc(6);
        for (int b = 0; b < 4; b++) begin
            mosi = b[0];
            wait_cyc(6);
            sck = 1'b1;
            wait_cyc(6);
            sck = 1'b0;
        end
        wait_cyc(2);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check1("mid_rst_miso", miso, 1'b0);
        check1("mid_rst_miso_oe", miso_oe, 1'b0);
        check1("mid_rst_tx_ready", tx_ready, 1'b1);
        check8("mid_rst_rx_data", rx_data, 8'h00);
        check1("mid_rst_rx_valid", rx_valid, 1'b0);
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_underrun", tx_underrun, 1'b0);
        wait_cyc(3);
        rst_n = 1'b1;
        for (int b = 0; b < 4; b++) begin
            mosi = ~b[0];
            wait_cyc(6);
            check1("ignored_miso", miso, 1'b0);
            sck = 1'b1;
            wait_cyc(6);
            sck = 1'b0;
        end
        wait_cyc(6);
        cs = 1'b1;
        wait_cyc(10);
        check8("t6_rx_untouched", rx_data, 8'h00);
        check1("t6_no_underrun", tx_underrun, 1'b0);
        clear_frame();
        f_mosi[0] = 8'hC9; f_load[0] = 1'b1; f_loadv[0] = 8'h81; f_load[1] = 1'b1; f_loadv[1] = 8'h00;
        run_frame();
        check8("t6_rx_data", rx_data, 8'hC9);
        check8("t6_miso", seen_miso[0], 8'h81);

        for (int fr = 0; fr < 25; fr++) begin
            clear_frame();
            f_n     = $urandom_range(1, 3);
            f_abort = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : 0;
            f_spur  = ($urandom_range(0, 2) == 0);
            for (int k = 0; k <= f_n; k++) begin
                f_mosi[k]  = 8'($urandom);
                f_load[k]  = ($urandom_range(0, 9) < 7);
                f_loadv[k] = 8'($urandom);
            end
            run_frame();
        end

        wait_cyc(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
